// File: rtl/enc_pkg.sv
// Shared constants for the registered round-robin / fixed-priority request encoder.
package enc_pkg;

    localparam int ENC_MODE_FIXED = 0;
    localparam int ENC_MODE_RR    = 1;
    localparam int ERR_CNT_W      = 8;

endpackage

// File: rtl/enc_pick.sv
// Combinational find-first-set starting at 'start' and wrapping W-1 -> 0.
// Returns idx=0 and none=1 for an all-zero request vector.
module enc_pick #(
    parameter int W     = 8,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             none
);

    // rot[k] is the request bit sitting k positions above start (modulo W)
    logic [W-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    for (genvar gi = 0; gi < W; gi++) begin : g_rot
        logic [IDX_W:0] pos;
        always_comb begin
            pos = {1'b0, start} + (IDX_W+1)'(gi);
            if (pos >= (IDX_W+1)'(W)) begin
                pos = pos - (IDX_W+1)'(W);
            end
        end
        assign rot[gi] = req[pos[IDX_W-1:0]];
    end

    // Descending scan so the smallest offset is the last one written
    always_comb begin
        off  = '0;
        none = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off  = IDX_W'(i);
                none = 1'b0;
            end
        end
    end

    always_comb begin
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (IDX_W+1)'(W)) begin
            sum = sum - (IDX_W+1)'(W);
        end
        idx = none ? '0 : sum[IDX_W-1:0];
    end

endmodule

// File: rtl/priority_encoder_rr.sv
// Registered W-to-log2(W) request encoder with valid/ready on both sides.
// Optional multi-hot flag and saturating error counter: define ENC_MULTIHOT_ERR_EN.
module priority_encoder_rr
    import enc_pkg::*;
#(
    parameter int W     = 8,
    parameter int IDX_W = $clog2(W),
    parameter int MODE  = ENC_MODE_FIXED
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_none
`ifdef ENC_MULTIHOT_ERR_EN
    ,
    output logic                 out_multi,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_none_q, out_none_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             accept;
    logic [IDX_W-1:0] pick_start;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_none;

    // The slot frees up when empty or when the current result retires this cycle
    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign pick_start = (MODE == ENC_MODE_RR) ? rr_ptr_q : '0;

    enc_pick #(
        .W     (W),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (in_req),
        .start (pick_start),
        .idx   (pick_idx),
        .none  (pick_none)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_none_d  = out_none_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_idx_d   = pick_idx;
            out_none_d  = pick_none;
            if ((MODE == ENC_MODE_RR) && !pick_none) begin
                rr_ptr_d = (pick_idx == IDX_W'(W - 1)) ? '0 : pick_idx + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_none_q  <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_none_q  <= out_none_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_none  = out_none_q;

`ifdef ENC_MULTIHOT_ERR_EN
    logic                 out_multi_q, out_multi_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 req_multi;

    // Clearing the lowest set bit leaves something behind only if >1 bit was set
    assign req_multi = |(in_req & (in_req - W'(1)));

    always_comb begin
        out_multi_d = out_multi_q;
        err_count_d = err_count_q;
        if (accept) begin
            out_multi_d = req_multi;
            if (req_multi && (err_count_q != {ERR_CNT_W{1'b1}})) begin
                err_count_d = err_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_multi_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            out_multi_q <= out_multi_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_multi = out_multi_q;
    assign err_count = err_count_q;
`else
`endif

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr: three instances (W=4 fixed, W=4 RR, W=5 RR) share stimulus,
// each checked every cycle against a reference model plus a directed vector table.
module tb_priority_encoder_rr;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [4:0] in_req;

    logic       ir0, ir1, ir2;
    logic       ov0, ov1, ov2;
    logic       on0, on1, on2;
    logic [1:0] oi0, oi1;
    logic [2:0] oi2;
`ifdef ENC_MULTIHOT_ERR_EN
    logic       om0, om1, om2;
    logic [7:0] ec0, ec1, ec2;
`endif

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    priority_encoder_rr #(.W(4), .MODE(0)) u_fix4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_req(in_req[3:0]),
        .out_valid(ov0), .out_ready(out_ready), .out_idx(oi0), .out_none(on0)
`ifdef ENC_MULTIHOT_ERR_EN
        , .out_multi(om0), .err_count(ec0)
`endif
    );

    priority_encoder_rr #(.W(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_req(in_req[3:0]),
        .out_valid(ov1), .out_ready(out_ready), .out_idx(oi1), .out_none(on1)
`ifdef ENC_MULTIHOT_ERR_EN
        , .out_multi(om1), .err_count(ec1)
`endif
    );

    priority_encoder_rr #(.W(5), .MODE(1)) u_rr5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_req(in_req),
        .out_valid(ov2), .out_ready(out_ready), .out_idx(oi2), .out_none(on2)
`ifdef ENC_MULTIHOT_ERR_EN
        , .out_multi(om2), .err_count(ec2)
`endif
    );

    int g_ir[3], g_v[3], g_idx[3], g_none[3];
    assign g_ir[0]   = int'(ir0);
    assign g_ir[1]   = int'(ir1);
    assign g_ir[2]   = int'(ir2);
    assign g_v[0]    = int'(ov0);
    assign g_v[1]    = int'(ov1);
    assign g_v[2]    = int'(ov2);
    assign g_idx[0]  = int'(oi0);
    assign g_idx[1]  = int'(oi1);
    assign g_idx[2]  = int'(oi2);
    assign g_none[0] = int'(on0);
    assign g_none[1] = int'(on1);
    assign g_none[2] = int'(on2);
`ifdef ENC_MULTIHOT_ERR_EN
    int g_multi[3], g_cnt[3];
    assign g_multi[0] = int'(om0);
    assign g_multi[1] = int'(om1);
    assign g_multi[2] = int'(om2);
    assign g_cnt[0]   = int'(ec0);
    assign g_cnt[1]   = int'(ec1);
    assign g_cnt[2]   = int'(ec2);
`endif

    // Reference model state per instance
    int m_valid[3], m_idx[3], m_none[3], m_ptr[3];
`ifdef ENC_MULTIHOT_ERR_EN
    int m_multi[3], m_cnt[3];
`endif
    int ir_snap[3];

    function automatic int wid(input int d);
        return (d == 2) ? 5 : 4;
    endfunction

    function automatic int is_rr(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    // First set position at or after ptr going upward, wrapping; -1 if none
    function automatic int ref_pick(input int w, input int ptr, input logic [4:0] req);
        logic [4:0] sh;
        for (int k = 0; k < w; k++) begin
            int p;
            p  = (ptr + k) % w;
            sh = req >> p;
            if (sh[0]) return p;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input int d, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0d want=%0d", nm, d, got, exp);
        end
    endtask

    task automatic model_step(input int d);
        logic [4:0] rq;
        int p;
        rq = (wid(d) == 4) ? (in_req & 5'h0F) : in_req;
        if (rst) begin
            m_valid[d] = 0; m_idx[d] = 0; m_none[d] = 0; m_ptr[d] = 0;
`ifdef ENC_MULTIHOT_ERR_EN
            m_multi[d] = 0; m_cnt[d] = 0;
`endif
        end else if (in_valid && (m_valid[d] == 0 || out_ready)) begin
            p = ref_pick(wid(d), (is_rr(d) == 1) ? m_ptr[d] : 0, rq);
            m_valid[d] = 1;
            m_none[d]  = (p < 0) ? 1 : 0;
            m_idx[d]   = (p < 0) ? 0 : p;
            if (is_rr(d) == 1 && p >= 0) m_ptr[d] = (p + 1) % wid(d);
`ifdef ENC_MULTIHOT_ERR_EN
            m_multi[d] = ($countones(rq) > 1) ? 1 : 0;
            if (m_multi[d] == 1 && m_cnt[d] < 255) m_cnt[d]++;
`endif
        end else if (out_ready) begin
            m_valid[d] = 0;
        end
    endtask

    task automatic check_model(input int d);
        chk("out_valid", d, g_v[d], m_valid[d]);
        chk("out_idx", d, g_idx[d], m_idx[d]);
        chk("out_none", d, g_none[d], m_none[d]);
`ifdef ENC_MULTIHOT_ERR_EN
        chk("out_multi", d, g_multi[d], m_multi[d]);
        chk("err_count", d, g_cnt[d], m_cnt[d]);
`endif
    endtask

    // Inputs must already be driven; checks in_ready before the edge, outputs after it
    task automatic run_cycle();
        #1;
        for (int d = 0; d < 3; d++) begin
            ir_snap[d] = g_ir[d];
            if (!rst) chk("in_ready", d, g_ir[d], (m_valid[d] == 0 || out_ready) ? 1 : 0);
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) model_step(d);
        #1;
        for (int d = 0; d < 3; d++) check_model(d);
    endtask

    typedef struct {
        bit         rst;
        bit         v;
        bit         r;
        logic [4:0] req;
        int         dut;
        bit         chk_ir;
        int         exp_ir;
        int         exp_v;
        bit         chk_res;
        int         exp_idx;
        int         exp_none;
    } vec_t;

    function automatic vec_t mk(input bit rs, input bit v, input bit r, input logic [4:0] req,
                                input int dut, input bit ci, input int eir, input int ev,
                                input bit cr, input int eidx, input int enone);
        vec_t t;
        t.rst = rs; t.v = v; t.r = r; t.req = req; t.dut = dut;
        t.chk_ir = ci; t.exp_ir = eir; t.exp_v = ev;
        t.chk_res = cr; t.exp_idx = eidx; t.exp_none = enone;
        return t;
    endfunction

    initial begin
        vec_t tbl[$];
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_req    = '0;
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 0; m_idx[d] = 0; m_none[d] = 0; m_ptr[d] = 0;
`ifdef ENC_MULTIHOT_ERR_EN
            m_multi[d] = 0; m_cnt[d] = 0;
`endif
        end

        // Fixed priority, one vector per cycle, then a zero vector and a retire
        tbl.push_back(mk(1, 0, 1, 5'b00000, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00001, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00010, 0, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00100, 0, 1, 1, 1, 1, 2, 0));
        tbl.push_back(mk(0, 1, 1, 5'b01000, 0, 1, 1, 1, 1, 3, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00110, 0, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00000, 0, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 5'b01111, 0, 1, 1, 0, 1, 0, 1));
        // Round-robin W=4: pointer advance, wrap, zero vector leaves pointer alone
        tbl.push_back(mk(1, 0, 1, 5'b00000, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00110, 1, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00110, 1, 1, 1, 1, 1, 2, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00110, 1, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00000, 1, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 5'b00100, 1, 1, 1, 1, 1, 2, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00010, 1, 1, 1, 1, 1, 1, 0));
        // Round-robin W=5: winner at W-1 wraps the pointer to 0
        tbl.push_back(mk(1, 0, 1, 5'b00000, 2, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 5'b10000, 2, 1, 1, 1, 1, 4, 0));
        tbl.push_back(mk(0, 1, 1, 5'b10001, 2, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00010, 2, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 5'b10001, 2, 1, 1, 1, 1, 4, 0));
        // Backpressure for 3 cycles then release, then reset during a held result
        tbl.push_back(mk(1, 0, 1, 5'b00000, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00001, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5'b00010, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5'b00010, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5'b00010, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00010, 0, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 5'b01000, 0, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 5'b00000, 0, 0, 0, 0, 1, 0, 0));
        // Reset in RR mode while held: pointer must return to 0
        tbl.push_back(mk(1, 0, 1, 5'b00000, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00110, 1, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 5'b00001, 1, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 5'b00000, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00110, 1, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 5'b00100, 1, 1, 1, 1, 1, 2, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            int d;
            d         = tbl[i].dut;
            rst       = tbl[i].rst;
            in_valid  = tbl[i].v;
            out_ready = tbl[i].r;
            in_req    = tbl[i].req;
            run_cycle();
            if (tbl[i].chk_ir) chk("row_in_ready", d, ir_snap[d], tbl[i].exp_ir);
            chk("row_valid", d, g_v[d], tbl[i].exp_v);
            if (tbl[i].chk_res) begin
                chk("row_idx", d, g_idx[d], tbl[i].exp_idx);
                chk("row_none", d, g_none[d], tbl[i].exp_none);
            end
            $display("row %0d dut%0d rst=%0b v=%0b r=%0b req=%05b -> valid=%0d idx=%0d none=%0d",
                     i, d, tbl[i].rst, tbl[i].v, tbl[i].r, tbl[i].req, g_v[d], g_idx[d], g_none[d]);
        end

`ifdef ENC_MULTIHOT_ERR_EN
        // Saturation of the multi-hot counter
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_req = '0;
        run_cycle();
        rst = 1'b0; in_valid = 1'b1; in_req = 5'b00110;
        for (int i = 0; i < 300; i++) begin
            run_cycle();
            if (i == 0) begin
                chk("multi_first", 0, g_multi[0], 1);
                chk("err_first", 0, g_cnt[0], 1);
            end
        end
        chk("err_sat", 0, g_cnt[0], 255);
        chk("err_sat", 2, g_cnt[2], 255);
        $display("saturation run: err_count dut0=%0d dut2=%0d", g_cnt[0], g_cnt[2]);
`endif

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_req    = ($urandom_range(0, 4) == 0) ? 5'b00000 : 5'($urandom);
            run_cycle();
            $display("rnd %0d rst=%0b v=%0b r=%0b req=%05b -> idx %0d/%0d/%0d", i, rst,
                     in_valid, out_ready, in_req, g_idx[0], g_idx[1], g_idx[2]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
